io_bus_arbiter: RTL
===================

IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of requesting masters (2..4).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum cycles waiting for slave ack.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports m_req, m_RW, m_handshake_1  input  NUM_MASTERS  per-master request, read/write, strobe.
REQ-006 SHALL have ports m_reg_address  input  NUM_MASTERS x 8  and  m_data_out  input  NUM_MASTERS x 32  per-master address/write data.
REQ-007 SHALL have ports m_grant, m_handshake_2  output  NUM_MASTERS  one-hot grant; ack routed to granted master only.
REQ-008 SHALL have port m_data_in  output  32  registered read data, shared by all masters.
REQ-009 SHALL have ports bus_RW, bus_handshake_1  output  1;  bus_reg_address  output  8;  bus_data_out  output  32  slave-side bus.
REQ-010 SHALL have ports bus_handshake_2  input  1  and  bus_data_in  input  32  slave ack and read data.
REQ-011 SHALL have ports timeout_err  output  1  and  err_master  output  2, present only with IO_BUS_TIMEOUT_EN.

Function
REQ-012 SHALL implement states IDLE, GRANTED, WAIT_ACK, WAIT_REL, WAIT_DONE, FLUSH (FLUSH only with macro).
REQ-013 IDLE: if any m_req, SHALL select winner round-robin from last_grant+1 and enter GRANTED with m_grant set on the next edge (1-cycle grant latency).
REQ-014 GRANTED: m_handshake_1 of granted master high -> WAIT_ACK; granted m_req low -> IDLE without transaction, pointer unchanged.
REQ-015 WAIT_ACK: bus_handshake_2 high -> latch bus_data_in into m_data_in, go WAIT_REL.
REQ-016 WAIT_REL: granted m_handshake_1 low -> WAIT_DONE; WAIT_DONE: bus_handshake_2 low -> IDLE, last_grant <= granted index, m_grant cleared.
REQ-017 bus_RW, bus_reg_address, bus_data_out SHALL be combinational mux of granted master inputs while m_grant nonzero, else 0.
REQ-018 bus_handshake_1 SHALL equal granted m_handshake_1 in WAIT_ACK/WAIT_REL only, else 0; non-granted m_handshake_1 ignored.
REQ-019 m_handshake_2[g] SHALL equal bus_handshake_2 for granted g in WAIT_ACK..WAIT_DONE; all others 0.
REQ-020 Requests arriving mid-transaction SHALL wait; grant never changes until return to IDLE.
REQ-021 Simultaneous requests SHALL be served in rotating order; no master starves longer than NUM_MASTERS-1 transactions.
REQ-022 bus_handshake_2 high while IDLE/GRANTED SHALL be ignored.

Reset
REQ-023 On reset low SHALL asynchronously force IDLE, last_grant = NUM_MASTERS-1 (master 0 wins first), all outputs and m_data_in 0.
REQ-024 Reset mid-transaction SHALL drop bus_handshake_1 immediately; no pending transaction resumes after release.

Configuration
REQ-025 With IO_BUS_TIMEOUT_EN defined: 8-bit counter cleared on WAIT_ACK entry; reaching TIMEOUT_CYCLES -> drop bus_handshake_1, pulse timeout_err 1 cycle, err_master = granted index, enter FLUSH.
REQ-026 FLUSH SHALL wait for granted m_handshake_1 low and bus_handshake_2 low, then IDLE with pointer advanced.
REQ-027 Without IO_BUS_TIMEOUT_EN: no counter, no FLUSH, no timeout ports; WAIT_ACK waits indefinitely.

Structure
REQ-028 arb_state_t enum and IO_BUS_ADDR_W/IO_BUS_DATA_W constants SHALL live in shared package types.
REQ-029 Round-robin selection SHALL be sub-module rr_priority_picker (req vector, last index -> one-hot winner, valid).

Verification
REQ-030 Single master 0 write addr 0x05 data 0xDEADBEEF -> grant 1 cycle after req, bus_data_out 0xDEADBEEF, four-phase completes, IDLE.
REQ-031 Read: slave returns 0x12345678 with ack -> m_data_in = 0x12345678 held after IDLE.
REQ-032 Both masters request continuously for 4 transactions -> grant order 0,1,0,1.
REQ-033 Master 1 drops req in GRANTED -> IDLE, no bus_handshake_1, next grant still master 1 if re-requested.
REQ-034 Macro on, slave silent -> timeout_err pulse exactly TIMEOUT_CYCLES after WAIT_ACK entry, err_master correct, return IDLE.
REQ-035 Reset asserted in WAIT_REL -> all outputs 0 same cycle, first grant after release to master 0.

Source files
------------

// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and constants for the IO bus arbiter.
// Optional feature macro: IO_BUS_TIMEOUT_EN adds the FLUSH state used after an ack timeout.
package io_bus_arbiter_pkg;

  localparam int IO_BUS_ADDR_W = 8;
  localparam int IO_BUS_DATA_W = 32;
  localparam int MAX_MASTERS   = 4;
  localparam int IDX_W         = 2;
  localparam int TMO_W         = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANTED   = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_REL  = 3'd3,
    WAIT_DONE = 3'd4
`ifdef IO_BUS_TIMEOUT_EN
    ,
    FLUSH     = 3'd5
`endif
  } arb_state_t;

  // Index of the set bit in a one-hot vector (0 when the vector is empty).
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Master-side and slave-side signal bundle of the IO bus arbiter.
// Modports: arb (the arbiter), master (requesting masters), slave (bus slave).
interface io_bus_arbiter_if
  import io_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2
);

  logic [NUM_MASTERS-1:0]                    m_req;
  logic [NUM_MASTERS-1:0]                    m_RW;
  logic [NUM_MASTERS-1:0]                    m_handshake_1;
  logic [NUM_MASTERS-1:0][IO_BUS_ADDR_W-1:0] m_reg_address;
  logic [NUM_MASTERS-1:0][IO_BUS_DATA_W-1:0] m_data_out;
  logic [NUM_MASTERS-1:0]                    m_grant;
  logic [NUM_MASTERS-1:0]                    m_handshake_2;
  logic [IO_BUS_DATA_W-1:0]                  m_data_in;

  logic                                      bus_RW;
  logic                                      bus_handshake_1;
  logic [IO_BUS_ADDR_W-1:0]                  bus_reg_address;
  logic [IO_BUS_DATA_W-1:0]                  bus_data_out;
  logic                                      bus_handshake_2;
  logic [IO_BUS_DATA_W-1:0]                  bus_data_in;

  modport arb (
    input  m_req, m_RW, m_handshake_1, m_reg_address, m_data_out,
    output m_grant, m_handshake_2, m_data_in,
    output bus_RW, bus_handshake_1, bus_reg_address, bus_data_out,
    input  bus_handshake_2, bus_data_in
  );

  modport master (
    output m_req, m_RW, m_handshake_1, m_reg_address, m_data_out,
    input  m_grant, m_handshake_2, m_data_in
  );

  modport slave (
    input  bus_RW, bus_handshake_1, bus_reg_address, bus_data_out,
    output bus_handshake_2, bus_data_in
  );

endinterface

// File: rtl/io_bus_arbiter_rr_priority_picker.sv
// Round-robin picker: the first requester after the last granted index wins.
module rr_priority_picker
  import io_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  output logic [NUM_MASTERS-1:0] winner,
  output logic                   valid
);

  // Scan last+1, last+2, ... (wrapping) and take the first active request.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (!valid && req[j] && (j == ((int'(last) + i) % NUM_MASTERS))) begin
          winner[j] = 1'b1;
          valid     = 1'b1;
        end else begin
          valid = valid;
        end
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter granting one of NUM_MASTERS masters a four-phase slave bus.
// Optional feature macro: IO_BUS_TIMEOUT_EN (ack timeout, timeout_err/err_master, FLUSH).
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  io_bus_arbiter_if.arb    bus
`ifdef IO_BUS_TIMEOUT_EN
  ,
  output logic             timeout_err,
  output logic [IDX_W-1:0] err_master
`endif
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_cfg_check
    $error("io_bus_arbiter: NUM_MASTERS must be 2..4 and TIMEOUT_CYCLES 1..255");
  end

  arb_state_t               state_r, state_s;
  logic [NUM_MASTERS-1:0]   grant_r, grant_s;
  logic [IDX_W-1:0]         last_r, last_s, gidx_s;
  logic [IO_BUS_DATA_W-1:0] din_r, din_s;
  logic [NUM_MASTERS-1:0]   pick_s;
  logic                     pick_valid_s;
  logic                     g_req_s, g_hs1_s, rw_s;
  logic [IO_BUS_ADDR_W-1:0] addr_s;
  logic [IO_BUS_DATA_W-1:0] dout_s;
  logic                     ack_phase_s;

`ifdef IO_BUS_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] cnt_r, cnt_s;
  logic             tmo_r, tmo_s;
  logic [IDX_W-1:0] errm_r, errm_s;
`endif

  rr_priority_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .req    (bus.m_req),
    .last   (last_r),
    .winner (pick_s),
    .valid  (pick_valid_s)
  );

  assign gidx_s = onehot_to_idx(MAX_MASTERS'(grant_r));

  // Route the granted master's request, strobe and bus fields (zero when nobody is granted).
  always_comb begin
    g_req_s = 1'b0;
    g_hs1_s = 1'b0;
    rw_s    = 1'b0;
    addr_s  = '0;
    dout_s  = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (grant_r[j]) begin
        g_req_s = g_req_s | bus.m_req[j];
        g_hs1_s = g_hs1_s | bus.m_handshake_1[j];
        rw_s    = rw_s | bus.m_RW[j];
        addr_s  = addr_s | bus.m_reg_address[j];
        dout_s  = dout_s | bus.m_data_out[j];
      end else begin
        g_req_s = g_req_s;
      end
    end
  end

  // Next-state logic; grant only changes on the way into or out of IDLE.
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    last_s  = last_r;
    din_s   = din_r;
`ifdef IO_BUS_TIMEOUT_EN
    cnt_s   = cnt_r;
    tmo_s   = 1'b0;
    errm_s  = errm_r;
`endif
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          grant_s = pick_s;
          state_s = GRANTED;
        end else begin
          grant_s = '0;
        end
      end
      GRANTED: begin
        if (!g_req_s) begin
          grant_s = '0;
          state_s = IDLE;
        end else if (g_hs1_s) begin
          state_s = WAIT_ACK;
`ifdef IO_BUS_TIMEOUT_EN
          cnt_s   = '0;
`endif
        end else begin
          state_s = GRANTED;
        end
      end
      WAIT_ACK: begin
        if (bus.bus_handshake_2) begin
          din_s   = bus.bus_data_in;
          state_s = WAIT_REL;
        end
`ifdef IO_BUS_TIMEOUT_EN
        else if (cnt_r == TMO_LAST) begin
          tmo_s   = 1'b1;
          errm_s  = gidx_s;
          state_s = FLUSH;
        end else begin
          cnt_s = cnt_r + TMO_W'(1);
        end
`else
        else begin
          state_s = WAIT_ACK;
        end
`endif
      end
      WAIT_REL: begin
        if (!g_hs1_s) begin
          state_s = WAIT_DONE;
        end else begin
          state_s = WAIT_REL;
        end
      end
      WAIT_DONE: begin
        if (!bus.bus_handshake_2) begin
          state_s = IDLE;
          last_s  = gidx_s;
          grant_s = '0;
        end else begin
          state_s = WAIT_DONE;
        end
      end
`ifdef IO_BUS_TIMEOUT_EN
      FLUSH: begin
        if (!g_hs1_s && !bus.bus_handshake_2) begin
          state_s = IDLE;
          last_s  = gidx_s;
          grant_s = '0;
        end else begin
          state_s = FLUSH;
        end
      end
`endif
      default: begin
        state_s = IDLE;
        grant_s = '0;
      end
    endcase
  end

  // Arbiter state, grant, round-robin pointer and latched read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      grant_r <= '0;
      last_r  <= IDX_W'(NUM_MASTERS - 1);
      din_r   <= '0;
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      last_r  <= last_s;
      din_r   <= din_s;
    end
  end

`ifdef IO_BUS_TIMEOUT_EN
  // Ack-wait counter and the one-cycle timeout report.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r  <= '0;
      tmo_r  <= 1'b0;
      errm_r <= '0;
    end else begin
      cnt_r  <= cnt_s;
      tmo_r  <= tmo_s;
      errm_r <= errm_s;
    end
  end

  assign timeout_err = tmo_r;
  assign err_master  = errm_r;
`endif

  assign ack_phase_s = (state_r == WAIT_ACK) || (state_r == WAIT_REL) || (state_r == WAIT_DONE);

  assign bus.m_grant         = grant_r;
  assign bus.m_data_in       = din_r;
  assign bus.m_handshake_2   = ack_phase_s ? (grant_r & {NUM_MASTERS{bus.bus_handshake_2}}) : '0;
  assign bus.bus_RW          = rw_s;
  assign bus.bus_reg_address = addr_s;
  assign bus.bus_data_out    = dout_s;
  assign bus.bus_handshake_1 = ((state_r == WAIT_ACK) || (state_r == WAIT_REL)) ? g_hs1_s : 1'b0;

endmodule
